period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
- Measures the period and high time of an incoming square wave, in clk cycles. This is the receive-side counterpart of the frequency generator's sweep/constant square-wave output.
- Used in loopback to check the generated oData frequency and sweep progression, and as a front-end for externally supplied tone inputs.
- Publishes one (period, high time) pair per completed input cycle, with a one-cycle valid strobe.

Parameters:
- WIDTH, 11, counter and result width in bits; matches the generator period width.
- SYNC_STAGES, 2, number of synchroniser flops on iSignal; minimum 2.
- MIN_PERIOD, 8, measured periods below this value are rejected as glitches.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- iReset_n  input  1  asynchronous active-low reset.
- iEnable  input  1  measurement enable; low forces IDLE.
- iSignal  input  1  asynchronous square wave to measure.
- oPeriod  output  WIDTH  last accepted period in clk cycles.
- oHigh_time  output  WIDTH  high-phase length, in clk cycles, of the same input cycle.
- oValid  output  1  one-cycle pulse when oPeriod/oHigh_time update.
- oTimeout  output  1  sticky flag: no rising edge within 2^WIDTH-1 cycles.
- oGlitch  output  1  one-cycle pulse when a period below MIN_PERIOD is rejected.

Behaviour:
- Reset (iReset_n low, asynchronous): all outputs 0, counters 0, synchroniser flops and previous-sample register 0, state IDLE.
- Front end:
  - iSignal passes through SYNC_STAGES flops; s is the final-stage output; d is s delayed by one cycle.
  - rise = s & ~d; fall = ~s & d.
- Latency: iSignal first sampled high at posedge k causes the oValid pulse and new outputs to appear after posedge k+SYNC_STAGES.
- State machine (states IDLE, ARM, MEASURE):
  - IDLE: cnt=0. If iEnable=1, go to ARM.
  - ARM: wait for rise. On rise: cnt<=1, hi<=0, go to MEASURE. The first edge never produces oValid.
  - MEASURE, default: cnt<=cnt+1 every cycle.
  - MEASURE, on fall: hi<=cnt.
  - MEASURE, on rise with cnt>=MIN_PERIOD: oPeriod<=cnt, oHigh_time<=hi, oValid<=1, oTimeout<=0, cnt<=1, hi<=0; stay in MEASURE.
  - MEASURE, on rise with cnt<MIN_PERIOD: outputs unchanged, oGlitch<=1, cnt<=1, hi<=0; stay in MEASURE.
  - MEASURE, cnt reaches 2^WIDTH-1 with no rise: oTimeout<=1, cnt<=0, go to ARM. oPeriod/oHigh_time hold their old values.
- Definitions:
  - Period = cycles between consecutive accepted-or-rejected rising edges.
  - High time = cycles from a rise to the following fall.
  - If no fall occurs within a period, oHigh_time reports 0.
- Counter never wraps; the saturation check takes priority over cnt+1.
- Simultaneous rise and timeout in the same cycle: rise wins. The measurement is accepted with cnt=2^WIDTH-1.
- iEnable low in any state: next state IDLE, cnt cleared. oPeriod, oHigh_time and oTimeout hold; oValid/oGlitch 0.
- Re-enable always passes through ARM, so no stale partial period is ever reported.
- oValid and oGlitch are mutually exclusive and never high on consecutive cycles for inputs slower than 2 cycles per phase.
- Result arithmetic is unsigned WIDTH bits; no rounding.

Test Plan:
- Reset, iEnable=1, iSignal square wave of period 100, high 50 (clk cycles) -> first rise gives no oValid; each later rise gives oValid pulse with oPeriod=100, oHigh_time=50; pulse SYNC_STAGES cycles after the sampled edge.
- Wave period changes from 100 (high 30) to 37 (high 10) mid-run -> next oValid reports 100/30, following ones report 37/10; no oGlitch.
- Rising edges 4 cycles apart (period 4 < MIN_PERIOD=8), then period 20 -> oGlitch pulses, oPeriod keeps its prior value; oValid with 20 once a 20-cycle period completes.
- iSignal held high after one rise -> oTimeout=1 after 2047 cycles, state ARM. Resume period-50 wave -> second rise gives oValid, oPeriod=50, oTimeout cleared.
- iReset_n pulsed low mid-period (asynchronously, between clk edges) -> all outputs 0 immediately; after release, first rise gives no oValid.
- iEnable dropped mid-period, then raised -> no oValid during low; first oValid after re-enable reports a full, correct period.

Source files
------------

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures period and high time of an asynchronous square wave in clk cycles
module period_meter #(
  parameter int WIDTH       = 11,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PERIOD  = 8
) (
  input  logic             clk,
  input  logic             iReset_n,
  input  logic             iEnable,
  input  logic             iSignal,
  output logic [WIDTH-1:0] oPeriod,
  output logic [WIDTH-1:0] oHigh_time,
  output logic             oValid,
  output logic             oTimeout,
  output logic             oGlitch
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] MIN_P   = WIDTH'(MIN_PERIOD);

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [WIDTH-1:0]       r_cnt;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       r_period;
  logic [WIDTH-1:0]       r_high;
  logic                   r_valid;
  logic                   r_timeout;
  logic                   r_glitch;

  logic w_s;
  logic w_rise;
  logic w_fall;
  logic w_start;
  logic w_accept;
  logic w_reject;
  logic w_timeout;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_prev;
  assign w_fall = ~w_s & r_prev;

  // Synchroniser chain plus the one-cycle-delayed copy used for edge detection
  always_ff @(posedge clk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], iSignal};
      r_prev <= w_s;
    end
  end

  // State register
  always_ff @(posedge clk or negedge iReset_n) begin
    if (!iReset_n) r_state <= IDLE;
    else           r_state <= w_next;
  end

  // Next-state logic; a rise in the saturating cycle keeps the measurement alive
  always_comb begin
    w_next = r_state;
    if (!iEnable) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next = ARM;
        ARM:     if (w_rise) w_next = MEASURE;
        MEASURE: if (!w_rise && r_cnt == CNT_MAX) w_next = ARM;
        default: w_next = IDLE;
      endcase
    end
  end

  // Per-cycle decisions derived from state and detected edges
  always_comb begin
    w_start   = iEnable && (r_state == ARM) && w_rise;
    w_accept  = iEnable && (r_state == MEASURE) && w_rise && (r_cnt >= MIN_P);
    w_reject  = iEnable && (r_state == MEASURE) && w_rise && (r_cnt < MIN_P);
    w_timeout = iEnable && (r_state == MEASURE) && !w_rise && (r_cnt == CNT_MAX);
  end

  // Counters and published results; results hold across disable and timeout
  always_ff @(posedge clk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_cnt     <= '0;
      r_hi      <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_glitch  <= 1'b0;
    end else begin
      r_valid  <= w_accept;
      r_glitch <= w_reject;
      if (!iEnable || r_state == IDLE) begin
        r_cnt <= '0;
      end else if (w_start || w_accept || w_reject) begin
        r_cnt <= {{(WIDTH-1){1'b0}}, 1'b1};
        r_hi  <= '0;
      end else if (w_timeout) begin
        r_cnt     <= '0;
        r_timeout <= 1'b1;
      end else if (r_state == MEASURE) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_fall) r_hi <= r_cnt;
      end
      if (w_accept) begin
        r_period  <= r_cnt;
        r_high    <= r_hi;
        r_timeout <= 1'b0;
      end
    end
  end

  assign oPeriod    = r_period;
  assign oHigh_time = r_high;
  assign oValid     = r_valid;
  assign oTimeout   = r_timeout;
  assign oGlitch    = r_glitch;

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - scoreboard bench for period_meter
module tb_period_meter;
  localparam int W    = 11;
  localparam int SS   = 2;
  localparam int MINP = 8;

  logic         clk = 1'b0;
  logic         iReset_n = 1'b0;
  logic         iEnable = 1'b0;
  logic         iSignal = 1'b0;
  logic [W-1:0] oPeriod;
  logic [W-1:0] oHigh_time;
  logic         oValid;
  logic         oTimeout;
  logic         oGlitch;

  period_meter #(.WIDTH(W), .SYNC_STAGES(SS), .MIN_PERIOD(MINP)) dut (
    .clk        (clk),
    .iReset_n   (iReset_n),
    .iEnable    (iEnable),
    .iSignal    (iSignal),
    .oPeriod    (oPeriod),
    .oHigh_time (oHigh_time),
    .oValid     (oValid),
    .oTimeout   (oTimeout),
    .oGlitch    (oGlitch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit glitch;
    int period;
    int high;
    int due;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state: wave described as (high, low) segments
  bit first = 1'b1;
  int prev_h = 0;
  int prev_l = 0;
  int mon_p = 0;
  int mon_h = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // a rise closes the previous segment; its full length is the period
  task automatic rise_event();
    exp_t e;
    if (!first) begin
      e.period = prev_h + prev_l;
      e.high   = prev_h;
      e.glitch = (e.period < MINP);
      e.due    = cyc + 1 + SS;
      sbq.push_back(e);
    end
    first = 1'b0;
  endtask

  // called at a negedge; returns at the negedge where the next rise belongs
  task automatic seg(input int h, input int l);
    iSignal = 1'b1;
    rise_event();
    prev_h = h;
    prev_l = l;
    repeat (h) @(negedge clk);
    iSignal = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic idle_low(input int n);
    repeat (n) @(negedge clk);
    prev_l += n;
  endtask

  // monitor: pops expectations whenever the DUT strobes, flags missed ones
  exp_t mon_e;
  always @(negedge clk) begin
    if (iReset_n) begin
      if (sbq.size() > 0 && cyc > sbq[0].due) begin
        mon_e = sbq.pop_front();
        total++;
        bad++;
        $display("FAIL missing_strobe: no output for period %0d due at cycle %0d", mon_e.period, mon_e.due);
      end
      if (oValid || oGlitch) begin
        check("valid_glitch_exclusive", int'(oValid && oGlitch), 0);
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: valid=%0d glitch=%0d period=%0d expected none", oValid, oGlitch, oPeriod);
        end else begin
          mon_e = sbq.pop_front();
          check("strobe_kind_glitch", int'(oGlitch), int'(mon_e.glitch));
          check("latency_cycle", cyc, mon_e.due);
          if (!mon_e.glitch) begin
            check("period", int'(oPeriod), mon_e.period);
            check("high_time", int'(oHigh_time), mon_e.high);
            check("timeout_cleared", int'(oTimeout), 0);
            mon_p = mon_e.period;
            mon_h = mon_e.high;
          end else begin
            check("glitch_period_hold", int'(oPeriod), mon_p);
            check("glitch_high_hold", int'(oHigh_time), mon_h);
          end
        end
      end
    end
  end

  task automatic async_reset();
    idle_low(10);
    @(posedge clk);
    #3 iReset_n = 1'b0;
    #1;
    check("rst_period", int'(oPeriod), 0);
    check("rst_high", int'(oHigh_time), 0);
    check("rst_valid", int'(oValid), 0);
    check("rst_timeout", int'(oTimeout), 0);
    check("rst_glitch", int'(oGlitch), 0);
    @(negedge clk);
    @(negedge clk);
    #2 iReset_n = 1'b1;
    first = 1'b1;
    mon_p = 0;
    mon_h = 0;
    @(negedge clk);
    idle_low(3);
  endtask

  initial begin
    int h;
    int l;
    repeat (3) @(negedge clk);
    check("reset_valid", int'(oValid), 0);
    check("reset_period", int'(oPeriod), 0);
    check("reset_timeout", int'(oTimeout), 0);
    #2 iReset_n = 1'b1;
    @(negedge clk);
    iEnable = 1'b1;
    first = 1'b1;
    idle_low(3);

    // steady 100/50 wave
    repeat (4) seg(50, 50);
    // period change 100/30 -> 37/10
    repeat (2) seg(30, 70);
    repeat (3) seg(10, 27);
    // glitches then 20-cycle period
    repeat (3) seg(2, 2);
    repeat (3) seg(10, 10);

    // randomized waves including sub-MIN_PERIOD ones
    for (int i = 0; i < 30; i++) begin
      h = $urandom_range(2, 40);
      l = $urandom_range(2, 40);
      seg(h, l);
    end

    // timeout: hold high after a rise
    iSignal = 1'b1;
    rise_event();
    repeat (2040) @(negedge clk);
    check("timeout_not_yet", int'(oTimeout), 0);
    repeat (20) @(negedge clk);
    check("timeout_set", int'(oTimeout), 1);
    check("timeout_period_hold", int'(oPeriod), mon_p);
    first = 1'b1;
    iSignal = 1'b0;
    repeat (10) @(negedge clk);
    repeat (3) seg(25, 25);

    // asynchronous reset mid-period
    seg(12, 20);
    async_reset();
    repeat (3) seg(15, 20);

    // enable dropped mid-period
    seg(9, 15);
    idle_low(4);
    iEnable = 1'b0;
    idle_low(20);
    iEnable = 1'b1;
    first = 1'b1;
    idle_low(3);
    repeat (3) seg(7, 18);

    idle_low(40);
    check("queue_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
